// File: rtl/serv_rf_dbg_pkg.sv
// Shared state encoding and address helper for the SERV register-file debug port.
package serv_rf_dbg_pkg;

  typedef enum logic [2:0] {IDLE, RD, RDLAST, WR, DONE} state_e;

  localparam int DEF_CSR_REGS = 4;
  localparam int NUM_REGS     = 32 + DEF_CSR_REGS;

  // RAM word address of narrow word k of register r (LSB word first).
  function automatic int word_addr(logic [5:0] r, logic [4:0] k, int rf_width);
    return int'(r) * (32 / rf_width) + int'(k);
  endfunction

endpackage

// File: rtl/serv_rf_dbg_port.sv
// Debug access port between serv_rf_ram_if and serv_rf_ram: CPU pass-through when idle,
// whole-register debug reads/writes when halted. Optional byte-select RMW: SERV_RF_DBG_BYTESEL_EN.
module serv_rf_dbg_port
  import serv_rf_dbg_pkg::*;
#(
  parameter int  RF_WIDTH = 8,
  parameter int  CSR_REGS = DEF_CSR_REGS,
  localparam int RF_L2D   = $clog2((32 + CSR_REGS) * 32 / RF_WIDTH)
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic [RF_L2D-1:0]   i_cpu_waddr,
  input  logic [RF_WIDTH-1:0] i_cpu_wdata,
  input  logic                i_cpu_wen,
  input  logic [RF_L2D-1:0]   i_cpu_raddr,
  input  logic                i_cpu_ren,
  output logic [RF_WIDTH-1:0] o_cpu_rdata,
  output logic [RF_L2D-1:0]   o_ram_waddr,
  output logic [RF_WIDTH-1:0] o_ram_wdata,
  output logic                o_ram_wen,
  output logic [RF_L2D-1:0]   o_ram_raddr,
  output logic                o_ram_ren,
  input  logic [RF_WIDTH-1:0] i_ram_rdata,
  input  logic                i_dbg_halted,
  input  logic                i_dbg_req,
  input  logic                i_dbg_we,
  input  logic [5:0]          i_dbg_reg,
  input  logic [31:0]         i_dbg_wdata,
`ifdef SERV_RF_DBG_BYTESEL_EN
  input  logic [3:0]          i_dbg_sel,
`endif
  output logic [31:0]         o_dbg_rdata,
  output logic                o_dbg_ack,
  output logic                o_dbg_err
);

  localparam int         N        = 32 / RF_WIDTH;
  localparam int         NREGS    = 32 + CSR_REGS;
  localparam logic [4:0] CNT_LAST = 5'(N - 1);

  state_e        state_q;
  logic [4:0]    cnt_q;
  logic [5:0]    reg_q;
  logic          is_rd_q;
  logic [31:0]   rbuf_q;
  logic [31:0]   wbuf_q;
  logic [31:0]   rdata_q;
  logic          ack_q;
  logic          err_q;
  logic          rst_q;

  logic [31:0]       rbuf_d;
  logic [31:0]       wr_merged_d;
  logic [RF_L2D-1:0] fsm_addr;
  logic              req_ok;
  logic              rmw_req;
  logic              strobe_ok;

  // Incoming word lands at the top; after N shifts word 0 sits in the LSBs.
  assign rbuf_d    = (rbuf_q >> RF_WIDTH) | (32'(i_ram_rdata) << (32 - RF_WIDTH));
  assign fsm_addr  = RF_L2D'(word_addr(reg_q, cnt_q, RF_WIDTH));
  assign req_ok    = i_dbg_halted && (int'(i_dbg_reg) < NREGS);
  assign strobe_ok = !i_rst && !rst_q;

`ifdef SERV_RF_DBG_BYTESEL_EN
  logic [3:0] sel_q;
  assign rmw_req = i_dbg_we && (i_dbg_sel != 4'hF);
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign wr_merged_d[gi*8 +: 8] = sel_q[gi] ? wbuf_q[gi*8 +: 8] : rbuf_d[gi*8 +: 8];
  end
`else
  assign rmw_req     = 1'b0;
  assign wr_merged_d = wbuf_q;
`endif

  assign o_cpu_rdata = i_ram_rdata;
  assign o_dbg_rdata = rdata_q;
  assign o_dbg_ack   = ack_q;
  assign o_dbg_err   = err_q;

  always_comb begin
    o_ram_waddr = i_cpu_waddr;
    o_ram_wdata = i_cpu_wdata;
    o_ram_wen   = i_cpu_wen;
    o_ram_raddr = i_cpu_raddr;
    o_ram_ren   = i_cpu_ren;
    if (state_q != IDLE) begin
      o_ram_waddr = fsm_addr;
      o_ram_wdata = wbuf_q[RF_WIDTH-1:0];
      o_ram_wen   = (state_q == WR);
      o_ram_raddr = fsm_addr;
      o_ram_ren   = (state_q == RD);
    end
    // Keep the RAM quiet through reset and the cycle after it.
    if (!strobe_ok) begin
      o_ram_wen = 1'b0;
      o_ram_ren = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= i_rst;
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      reg_q   <= '0;
      is_rd_q <= 1'b0;
      rbuf_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef SERV_RF_DBG_BYTESEL_EN
      sel_q   <= 4'hF;
`endif
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_dbg_req) begin
            reg_q   <= i_dbg_reg;
            wbuf_q  <= i_dbg_wdata;
            is_rd_q <= !i_dbg_we;
            cnt_q   <= '0;
`ifdef SERV_RF_DBG_BYTESEL_EN
            sel_q   <= i_dbg_sel;
`endif
            if (!req_ok) begin
              state_q <= DONE;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
            end else if (i_dbg_reg == '0) begin
              state_q <= DONE;
              ack_q   <= 1'b1;
              if (!i_dbg_we) rdata_q <= '0;
            end else if (!i_dbg_we || rmw_req) begin
              state_q <= RD;
            end else begin
              state_q <= WR;
            end
          end
        end
        RD: begin
          if (cnt_q != '0) rbuf_q <= rbuf_d;
          if (cnt_q == CNT_LAST) state_q <= RDLAST;
          else                   cnt_q   <= cnt_q + 5'd1;
        end
        RDLAST: begin
          rbuf_q <= rbuf_d;
          cnt_q  <= '0;
          if (is_rd_q) begin
            rdata_q <= rbuf_d;
            state_q <= DONE;
            ack_q   <= 1'b1;
          end else begin
            wbuf_q  <= wr_merged_d;
            state_q <= WR;
          end
        end
        WR: begin
          wbuf_q <= wbuf_q >> RF_WIDTH;
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_rf_dbg_port.sv
// Directed bench for serv_rf_dbg_port: three instances (RF_WIDTH 8, 2, 32) share the debug
// request lines, each backed by a registered-read RAM model.
module tb_serv_rf_dbg_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        halted, req, we;
  logic [5:0]  dreg;
  logic [31:0] dwdata;
  logic [3:0]  sel;

  // RF_WIDTH=8 instance
  logic [7:0]  c8_waddr, c8_raddr, c8_wdata, c8_rdata;
  logic        c8_wen, c8_ren;
  logic [7:0]  r8_waddr, r8_raddr, r8_wdata, r8_rdata;
  logic        r8_wen, r8_ren;
  logic [31:0] d8_rdata;
  logic        ack8, err8;
  logic [7:0]  mem8 [256];

  // RF_WIDTH=2 instance
  logic [9:0]  c2_addr;
  logic [1:0]  c2_wdata, c2_rdata;
  logic        c2_en;
  logic [9:0]  r2_waddr, r2_raddr;
  logic [1:0]  r2_wdata, r2_rdata;
  logic        r2_wen, r2_ren;
  logic [31:0] d2_rdata;
  logic        ack2, err2;
  logic [1:0]  mem2 [1024];

  // RF_WIDTH=32 instance
  logic [5:0]  c32_addr;
  logic [31:0] c32_wdata, c32_rdata;
  logic        c32_en;
  logic [5:0]  r32_waddr, r32_raddr;
  logic [31:0] r32_wdata, r32_rdata;
  logic        r32_wen, r32_ren;
  logic [31:0] d32_rdata;
  logic        ack32, err32;
  logic [31:0] mem32 [64];

  always @(posedge clk) begin
    if (r8_wen)  mem8[r8_waddr]   <= r8_wdata;
    if (r8_ren)  r8_rdata         <= mem8[r8_raddr];
    if (r2_wen)  mem2[r2_waddr]   <= r2_wdata;
    if (r2_ren)  r2_rdata         <= mem2[r2_raddr];
    if (r32_wen) mem32[r32_waddr] <= r32_wdata;
    if (r32_ren) r32_rdata        <= mem32[r32_raddr];
  end

  serv_rf_dbg_port #(.RF_WIDTH(8), .CSR_REGS(4)) u8 (
    .clk(clk), .i_rst(rst),
    .i_cpu_waddr(c8_waddr), .i_cpu_wdata(c8_wdata), .i_cpu_wen(c8_wen),
    .i_cpu_raddr(c8_raddr), .i_cpu_ren(c8_ren), .o_cpu_rdata(c8_rdata),
    .o_ram_waddr(r8_waddr), .o_ram_wdata(r8_wdata), .o_ram_wen(r8_wen),
    .o_ram_raddr(r8_raddr), .o_ram_ren(r8_ren), .i_ram_rdata(r8_rdata),
    .i_dbg_halted(halted), .i_dbg_req(req), .i_dbg_we(we), .i_dbg_reg(dreg),
    .i_dbg_wdata(dwdata),
`ifdef SERV_RF_DBG_BYTESEL_EN
    .i_dbg_sel(sel),
`endif
    .o_dbg_rdata(d8_rdata), .o_dbg_ack(ack8), .o_dbg_err(err8)
  );

  serv_rf_dbg_port #(.RF_WIDTH(2), .CSR_REGS(4)) u2 (
    .clk(clk), .i_rst(rst),
    .i_cpu_waddr(c2_addr), .i_cpu_wdata(c2_wdata), .i_cpu_wen(c2_en),
    .i_cpu_raddr(c2_addr), .i_cpu_ren(c2_en), .o_cpu_rdata(c2_rdata),
    .o_ram_waddr(r2_waddr), .o_ram_wdata(r2_wdata), .o_ram_wen(r2_wen),
    .o_ram_raddr(r2_raddr), .o_ram_ren(r2_ren), .i_ram_rdata(r2_rdata),
    .i_dbg_halted(halted), .i_dbg_req(req), .i_dbg_we(we), .i_dbg_reg(dreg),
    .i_dbg_wdata(dwdata),
`ifdef SERV_RF_DBG_BYTESEL_EN
    .i_dbg_sel(sel),
`endif
    .o_dbg_rdata(d2_rdata), .o_dbg_ack(ack2), .o_dbg_err(err2)
  );

  serv_rf_dbg_port #(.RF_WIDTH(32), .CSR_REGS(4)) u32 (
    .clk(clk), .i_rst(rst),
    .i_cpu_waddr(c32_addr), .i_cpu_wdata(c32_wdata), .i_cpu_wen(c32_en),
    .i_cpu_raddr(c32_addr), .i_cpu_ren(c32_en), .o_cpu_rdata(c32_rdata),
    .o_ram_waddr(r32_waddr), .o_ram_wdata(r32_wdata), .o_ram_wen(r32_wen),
    .o_ram_raddr(r32_raddr), .o_ram_ren(r32_ren), .i_ram_rdata(r32_rdata),
    .i_dbg_halted(halted), .i_dbg_req(req), .i_dbg_we(we), .i_dbg_reg(dreg),
    .i_dbg_wdata(dwdata),
`ifdef SERV_RF_DBG_BYTESEL_EN
    .i_dbg_sel(sel),
`endif
    .o_dbg_rdata(d32_rdata), .o_dbg_ack(ack32), .o_dbg_err(err32)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Per-transaction observations: [0]=W8, [1]=W2, [2]=W32; cycle 1 is T+1.
  int          ack_cyc [3];
  int          ack_cnt [3];
  logic        err_at  [3];
  logic [31:0] rd_at   [3];
  logic        tr_wen   [48];
  logic        tr_ren   [48];
  logic [7:0]  tr_waddr [48];
  logic [7:0]  tr_wdata [48];
  logic [7:0]  tr_raddr [48];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xact(input bit w, input logic [5:0] r, input logic [31:0] d,
                      input logic [3:0] s, input bit drop_halt);
    req = 1'b1; we = w; dreg = r; dwdata = d; sel = s;
    for (int i = 0; i < 3; i++) begin
      ack_cyc[i] = -1; ack_cnt[i] = 0; err_at[i] = 1'bx; rd_at[i] = 'x;
    end
    for (int c = 1; c < 48; c++) begin
      tick();
      if (c == 1) begin
        req = 1'b0; dreg = 6'h3F; dwdata = ~d;
      end
      if (c == 2 && drop_halt) halted = 1'b0;
      tr_wen[c] = r8_wen; tr_ren[c] = r8_ren;
      tr_waddr[c] = r8_waddr; tr_wdata[c] = r8_wdata; tr_raddr[c] = r8_raddr;
      if (ack8) begin
        ack_cnt[0]++;
        if (ack_cyc[0] < 0) begin ack_cyc[0] = c; err_at[0] = err8; rd_at[0] = d8_rdata; end
      end
      if (ack2) begin
        ack_cnt[1]++;
        if (ack_cyc[1] < 0) begin ack_cyc[1] = c; err_at[1] = err2; rd_at[1] = d2_rdata; end
      end
      if (ack32) begin
        ack_cnt[2]++;
        if (ack_cyc[2] < 0) begin ack_cyc[2] = c; err_at[2] = err32; rd_at[2] = d32_rdata; end
      end
    end
    $display("xact we=%0b reg=%0d data=%h: ack@ %0d/%0d/%0d", w, r, d,
             ack_cyc[0], ack_cyc[1], ack_cyc[2]);
  endtask

  task automatic chk_ack(input string tag, input int l8, input int l2, input int l32,
                         input bit e);
    chk({tag, " ack_lat_w8"},  ack_cyc[0], l8);
    chk({tag, " ack_lat_w2"},  ack_cyc[1], l2);
    chk({tag, " ack_lat_w32"}, ack_cyc[2], l32);
    chk({tag, " ack_cnt_w8"},  ack_cnt[0], 1);
    chk({tag, " ack_cnt_w2"},  ack_cnt[1], 1);
    chk({tag, " ack_cnt_w32"}, ack_cnt[2], 1);
    chk({tag, " err_w8"},  {31'd0, err_at[0]}, {31'd0, e});
    chk({tag, " err_w2"},  {31'd0, err_at[1]}, {31'd0, e});
    chk({tag, " err_w32"}, {31'd0, err_at[2]}, {31'd0, e});
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] exp);
    chk({tag, " rdata_w8"},  rd_at[0], exp);
    chk({tag, " rdata_w2"},  rd_at[1], exp);
    chk({tag, " rdata_w32"}, rd_at[2], exp);
  endtask

  initial begin
    int noack;
    rst = 1'b1; halted = 1'b1; req = 1'b0; we = 1'b0; dreg = '0; dwdata = '0; sel = 4'hF;
    c8_waddr = 8'h11; c8_wdata = 8'h5A; c8_wen = 1'b0; c8_raddr = 8'h42; c8_ren = 1'b1;
    c2_addr = '0; c2_wdata = '0; c2_en = 1'b0;
    c32_addr = '0; c32_wdata = '0; c32_en = 1'b0;

    // Reset behaviour and pass-through
    tick();
    chk("rst ack", {31'd0, ack8}, 32'd0);
    chk("rst err", {31'd0, err8}, 32'd0);
    chk("rst rdata", d8_rdata, 32'd0);
    chk("rst ren_in_reset", {31'd0, r8_ren}, 32'd0);
    rst = 1'b0;
    chk("rst ren_after_reset", {31'd0, r8_ren}, 32'd0);
    tick();
    chk("pass ren", {31'd0, r8_ren}, 32'd1);
    chk("pass raddr", {24'd0, r8_raddr}, 32'h42);
    chk("pass waddr", {24'd0, r8_waddr}, 32'h11);

    // 1: write x5, CPU read strobe must stay blocked
    xact(1'b1, 6'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    chk_ack("wr x5", 5, 17, 2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wr x5 wen%0d", k),   {31'd0, tr_wen[k+1]}, 32'd1);
      chk($sformatf("wr x5 waddr%0d", k), {24'd0, tr_waddr[k+1]}, 32'(20 + k));
      chk($sformatf("wr x5 ren%0d", k),   {31'd0, tr_ren[k+1]}, 32'd0);
    end
    chk("wr x5 wdata0", {24'd0, tr_wdata[1]}, 32'hEF);
    chk("wr x5 wdata1", {24'd0, tr_wdata[2]}, 32'hBE);
    chk("wr x5 wdata2", {24'd0, tr_wdata[3]}, 32'hAD);
    chk("wr x5 wdata3", {24'd0, tr_wdata[4]}, 32'hDE);
    chk("wr x5 wen_done", {31'd0, tr_wen[5]}, 32'd0);
    chk("wr x5 pass_resume", {31'd0, tr_ren[6]}, 32'd1);

    // 2: read x5 back
    xact(1'b0, 6'd5, 32'h0, 4'hF, 1'b0);
    chk_ack("rd x5", 6, 18, 3, 1'b0);
    chk_rd("rd x5", 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rd x5 ren%0d", k),   {31'd0, tr_ren[k+1]}, 32'd1);
      chk($sformatf("rd x5 raddr%0d", k), {24'd0, tr_raddr[k+1]}, 32'(20 + k));
    end
    chk("rd x5 ren_last", {31'd0, tr_ren[5]}, 32'd0);
    chk("rd x5 rdata_hold", d8_rdata, 32'hDEADBEEF);

    // 3: not halted -> rejected, no FSM read
    halted = 1'b0; c8_raddr = 8'h33;
    xact(1'b0, 6'd1, 32'h0, 4'hF, 1'b0);
    chk_ack("rej halt", 1, 1, 1, 1'b1);
    chk("rej halt no_fsm_rd", {31'd0, tr_ren[1] && (tr_raddr[1] != 8'h33)}, 32'd0);
    chk("rej halt pass_ren", {31'd0, tr_ren[2]}, 32'd1);
    chk("rej halt pass_raddr", {24'd0, tr_raddr[2]}, 32'h33);
    halted = 1'b1;

    // 4: x0 and out-of-range register
    xact(1'b1, 6'd0, 32'h1, 4'hF, 1'b0);
    chk_ack("wr x0", 1, 1, 1, 1'b0);
    chk("wr x0 no_wen", {31'd0, tr_wen[1] | tr_wen[2]}, 32'd0);
    xact(1'b0, 6'd0, 32'h0, 4'hF, 1'b0);
    chk_ack("rd x0", 1, 1, 1, 1'b0);
    chk_rd("rd x0", 32'h0);
    xact(1'b0, 6'd36, 32'h0, 4'hF, 1'b0);
    chk_ack("rd r36", 1, 1, 1, 1'b1);

    // Highest legal slot; halt dropped mid-read must not abort it
    xact(1'b1, 6'd35, 32'h12345678, 4'hF, 1'b0);
    chk_ack("wr r35", 5, 17, 2, 1'b0);
    chk("wr r35 waddr0", {24'd0, tr_waddr[1]}, 32'd140);
    chk("wr r35 waddr3", {24'd0, tr_waddr[4]}, 32'd143);
    xact(1'b0, 6'd35, 32'h0, 4'hF, 1'b1);
    chk_ack("rd r35 drop_halt", 6, 18, 3, 1'b0);
    chk_rd("rd r35 drop_halt", 32'h12345678);
    halted = 1'b1;

    // 6: CSR slot 33 on all widths
    xact(1'b1, 6'd33, 32'hCAFEF00D, 4'hF, 1'b0);
    chk_ack("wr r33", 5, 17, 2, 1'b0);
    xact(1'b0, 6'd33, 32'h0, 4'hF, 1'b0);
    chk_ack("rd r33", 6, 18, 3, 1'b0);
    chk_rd("rd r33", 32'hCAFEF00D);

    // 5: reset in the middle of a read
    c8_ren = 1'b0;
    req = 1'b1; we = 1'b0; dreg = 6'd5;
    tick();
    req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    noack = 0;
    for (int c = 3; c < 12; c++) begin
      if (c <= 6) chk($sformatf("rst_mid ren T+%0d", c), {31'd0, r8_ren}, 32'd0);
      if (ack8 || ack2 || ack32) noack++;
      tick();
    end
    chk("rst_mid no_ack", noack, 0);
    xact(1'b0, 6'd5, 32'h0, 4'hF, 1'b0);
    chk_ack("rd x5 after_rst", 6, 18, 3, 1'b0);
    chk_rd("rd x5 after_rst", 32'hDEADBEEF);

`ifdef SERV_RF_DBG_BYTESEL_EN
    xact(1'b1, 6'd7, 32'h11223344, 4'hF, 1'b0);
    chk_ack("wr x7 full", 5, 17, 2, 1'b0);
    xact(1'b1, 6'd7, 32'hAAAAAAAA, 4'b0010, 1'b0);
    chk_ack("rmw x7", 10, 34, 4, 1'b0);
    xact(1'b0, 6'd7, 32'h0, 4'hF, 1'b0);
    chk_ack("rd x7", 6, 18, 3, 1'b0);
    chk_rd("rd x7", 32'h1122AA44);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
